// File: rtl/fft_mult_sched.sv
// fft_mult_sched: issue/write-back scheduler for the radix-2 DIT FFT twiddle multiplier.
// Define FFT_SCHED_CYCLE_CNT_EN to enable the busy-cycle counter on cycles_o.
module fft_mult_sched #(
  parameter int LOG2N    = 10,
  parameter int MULT_LAT = 5,
  parameter int Q_DEPTH  = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic                     hold_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [$clog2(LOG2N)-1:0] stage_o,
  output logic                     mult_valid_o,
  output logic [LOG2N-1:0]         rd_addr_o,
  output logic [LOG2N-2:0]         tw_addr_o,
  input  logic                     mult_valid_i,
  output logic                     wr_en_o,
  output logic [LOG2N-1:0]         wr_addr_o,
  output logic                     err_o,
  output logic [31:0]              cycles_o
);

  localparam int SW = $clog2(LOG2N);
  localparam int KW = LOG2N - 1;
  localparam int QW = $clog2(Q_DEPTH);
  localparam int CW = QW + 1;

  localparam logic [SW-1:0] LAST_STAGE = SW'(LOG2N - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // A shallower queue still works; issue simply throttles on full.
  if (Q_DEPTH < MULT_LAT + 1) begin : g_q_shallow
  end

  logic [1:0]       r_state;
  logic [SW-1:0]    r_stage;
  logic [KW-1:0]    r_k;
  logic             r_mv;
  logic [LOG2N-1:0] r_rd;
  logic [KW-1:0]    r_tw;
  logic             r_err;

  logic [LOG2N-1:0] r_q [Q_DEPTH];
  logic [QW-1:0]    r_wp;
  logic [QW-1:0]    r_rp;
  logic [CW-1:0]    r_cnt;

  logic [LOG2N-1:0] w_k_ext;
  logic [LOG2N-1:0] w_span;
  logic [LOG2N-1:0] w_grp;
  logic [KW-1:0]    w_mask;
  logic [KW-1:0]    w_pos;
  logic [LOG2N-1:0] w_rd;
  logic [KW-1:0]    w_tw;

  logic w_q_empty;
  logic w_q_full;
  logic w_issue;
  logic w_pop;
  logic w_last_k;
  logic w_last_stage;
  logic w_drained;

  // rd = {grp, 1'b1, pos}; the mask form avoids a span that overflows KW bits.
  assign w_k_ext = {1'b0, r_k};
  assign w_span  = LOG2N'(1) << r_stage;
  assign w_grp   = w_k_ext >> r_stage;
  assign w_mask  = ~({KW{1'b1}} << r_stage);
  assign w_pos   = r_k & w_mask;

  assign w_rd = ((w_grp << r_stage) << 1)
              + {1'b0, w_pos}
              + w_span;

  assign w_tw = w_pos << (LAST_STAGE - r_stage);

  assign w_q_empty = (r_cnt == '0);
  assign w_q_full  = (r_cnt == CW'(Q_DEPTH));

  assign w_issue = (r_state == S_ISSUE)
                 && !hold_i
                 && !w_q_full;

  assign w_pop = mult_valid_i && !w_q_empty;

  assign w_last_k     = (r_k == {KW{1'b1}});
  assign w_last_stage = (r_stage == LAST_STAGE);
  assign w_drained    = w_q_empty && !w_pop;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_stage <= '0;
      r_k     <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_state <= S_ISSUE;
            r_stage <= '0;
            r_k     <= '0;
          end
        end
        S_ISSUE: begin
          if (w_issue) begin
            r_k <= r_k + 1'b1;
            if (w_last_k) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (w_drained) begin
            if (w_last_stage) begin
              r_state <= S_DONE;
            end else begin
              r_stage <= r_stage + 1'b1;
              r_k     <= '0;
              r_state <= S_ISSUE;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mv <= 1'b0;
      r_rd <= '0;
      r_tw <= '0;
    end else begin
      r_mv <= w_issue;
      if (w_issue) begin
        r_rd <= w_rd;
        r_tw <= w_tw;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < Q_DEPTH; i++) begin
        r_q[i] <= '0;
      end
    end else begin
      if (w_issue) begin
        r_q[r_wp] <= w_rd;
        r_wp      <= r_wp + 1'b1;
      end
      if (w_pop) begin
        r_rp <= r_rp + 1'b1;
      end
      unique case (1'b1)
        w_issue && !w_pop: r_cnt <= r_cnt + 1'b1;
        w_pop && !w_issue: r_cnt <= r_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err <= 1'b0;
    end else if (mult_valid_i && w_q_empty) begin
      r_err <= 1'b1;
    end
  end

`ifdef FFT_SCHED_CYCLE_CNT_EN
  logic [31:0] r_cycles;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cycles <= '0;
    end else if ((r_state == S_IDLE) && start_i) begin
      r_cycles <= '0;
    end else if (busy_o) begin
      r_cycles <= r_cycles + 32'd1;
    end
  end

  assign cycles_o = r_cycles;
`else
  assign cycles_o = '0;
`endif

  assign busy_o = (r_state == S_ISSUE)
               || (r_state == S_DRAIN);
  assign done_o = (r_state == S_DONE);

  assign stage_o      = r_stage;
  assign mult_valid_o = r_mv;
  assign rd_addr_o    = r_rd;
  assign tw_addr_o    = r_tw;
  assign wr_en_o      = w_pop;
  assign wr_addr_o    = r_q[r_rp];
  assign err_o        = r_err;

endmodule
